// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   state_e  : arbiter FSM encoding (idle / burst-owning)
//   clog2_f  : ceiling log2, sizes grant index and burst counter
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Ceiling log2 for constant width calculations.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ producers / FIFO write controller and the arbiter.
//   req_valid/req_data/req_last/req_ready : per-producer word handshake
//   wfull/winc/wdata                      : FIFO write port
//   busy/grant_id                         : current grant status
// modport slave  : arbiter side
// modport master : producers + FIFO side (environment)
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int GID_W = clog2_f(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          busy;
    logic [GID_W-1:0]              grant_id;

    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, busy, grant_id
    );

    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, busy, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   rr_ptr_i  : last winner; search starts at rr_ptr_i+1 (mod NUM_REQ)
//   winner_o  : first requester found by the search
//   any_req_o : at least one request present
module fifo_wr_arbiter_rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = clog2_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_req_o
);

    // Scan from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        winner_o  = '0;
        any_req_o = |req_i;
        for (int k = NUM_REQ; k >= 1; k--) begin
            winner_o = req_i[(int'(rr_ptr_i) + k) % NUM_REQ]
                       ? PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ)
                       : winner_o;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between NUM_REQ producers with round-robin
// arbitration and packet lock (grant held until last word or MAX_BURST words).
//   w_clk : write-domain clock
//   w_rst : asynchronous active-low reset
//   bus   : producer handshakes, FIFO write port, grant status (slave modport)
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic              w_clk,
    input  logic              w_rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int PTR_W = clog2_f(NUM_REQ);
    localparam int CNT_W = clog2_f(MAX_BURST + 1);

    state_e               state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     grant_q;
    logic [CNT_W-1:0]     burst_cnt_q;

    logic [PTR_W-1:0]      winner_s;
    logic                  any_req_s;
    logic                  xfer_s;
    logic                  release_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    fifo_wr_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i     (bus.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner_s),
        .any_req_o (any_req_s)
    );

    // Write-port muxing. Outputs derive from registered state so an async
    // reset clears them immediately; wfull gates both ready and winc.
    always_comb begin
        req_ready_s = '0;
        xfer_s      = 1'b0;
        wdata_s     = '0;
        if (state_q == ST_BURST) begin
            req_ready_s[grant_q] = ~bus.wfull;
            xfer_s               = bus.req_valid[grant_q] & ~bus.wfull;
        end else begin
            req_ready_s = '0;
            xfer_s      = 1'b0;
        end
        if (xfer_s) begin
            wdata_s = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wdata_s = '0;
        end
    end

    // The transfer that carries last, or that fills the burst, ends the grant.
    assign release_s = bus.req_last[grant_q] |
                       (burst_cnt_q == CNT_W'(MAX_BURST - 1));

    // Arbiter FSM: one IDLE cycle picks a winner, BURST counts transfers.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            grant_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_q     <= winner_s;
                        rr_ptr_q    <= winner_s;
                        burst_cnt_q <= '0;
                        state_q     <= ST_BURST;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (xfer_s) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                        state_q     <= release_s ? ST_IDLE : ST_BURST;
                    end else begin
                        state_q     <= ST_BURST;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.winc      = xfer_s;
    assign bus.wdata     = wdata_s;
    assign bus.busy      = (state_q == ST_BURST);
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: the driver advances a transaction-level
// model of producers and the round-robin/packet-lock rules, pushing expected
// per-cycle status and expected FIFO writes; a monitor pops and compares.
module tb_fifo_wr_arbiter;
    import fifo_wr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int GW = $clog2(N);

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;
    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic          busy;
        logic [GW-1:0] gid;
        logic [N-1:0]  ready;
        logic          winc;
    } stat_t;

    typedef struct packed {
        logic [GW-1:0] id;
        logic [DW-1:0] d;
    } wr_t;

    int n_checks = 0;
    int n_pass   = 0;

    // producer state: pending word per producer, plus scripted words
    logic [N-1:0]  pv;
    logic [N-1:0]  pl;
    logic [DW-1:0] pd [N];
    logic [DW:0]   gen_q [N][$];

    // reference arbitration state
    int owner = -1;
    int ptr   = N - 1;
    int cnt   = 0;

    stat_t stat_q [$];
    wr_t   wr_q   [$];
    stat_t mon_s;
    wr_t   mon_w;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // One clock of stimulus: refresh producers, drive, predict, advance model.
    task automatic step(input logic [N-1:0] rnd_en, input int full_pct, input int last_pct);
        stat_t s;
        logic [N*DW-1:0] dd;
        logic wf;
        bit found;
        @(posedge w_clk);
        #1;
        w_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!pv[i]) begin
                if (gen_q[i].size() > 0) begin
                    {pl[i], pd[i]} = gen_q[i].pop_front();
                    pv[i] = 1'b1;
                end else if (rnd_en[i] && ($urandom_range(0, 99) < 60)) begin
                    pd[i] = DW'($urandom);
                    pl[i] = ($urandom_range(0, 99) < last_pct);
                    pv[i] = 1'b1;
                end
            end
        end
        wf = ($urandom_range(0, 99) < full_pct);
        for (int i = 0; i < N; i++) dd[i*DW +: DW] = pd[i];
        bus.req_valid = pv;
        bus.req_last  = pl;
        bus.req_data  = dd;
        bus.wfull     = wf;

        s = '0;
        s.busy = (owner >= 0);
        if (owner >= 0) begin
            s.gid        = GW'(owner);
            s.ready[owner] = !wf;
            s.winc       = pv[owner] && !wf;
        end
        stat_q.push_back(s);
        if (s.winc) wr_q.push_back({GW'(owner), pd[owner]});

        if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && pv[(ptr + k) % N]) begin
                    found = 1'b1;
                    owner = (ptr + k) % N;
                    ptr   = owner;
                    cnt   = 0;
                end
            end
        end else if (s.winc) begin
            cnt++;
            pv[owner] = 1'b0;
            if (pl[owner] || cnt == MB) owner = -1;
        end
    endtask

    function automatic bit work_left();
        bit r;
        r = (owner >= 0) || (pv != '0);
        for (int i = 0; i < N; i++) r = r || (gen_q[i].size() > 0);
        return r;
    endfunction

    // Run until idle; feed a closing word to an owner that has run dry.
    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (work_left() && c < maxc) begin
            if (owner >= 0 && !pv[owner] && gen_q[owner].size() == 0)
                gen_q[owner].push_back({1'b1, DW'($urandom)});
            step('0, 0, 0);
            c++;
        end
        chk("drain_bound", 32'(work_left()), 32'd0);
    endtask

    task automatic wait_owner(input int id, input int n);
        int c;
        c = 0;
        while (!(owner == id && cnt >= n) && c < 60) begin
            step('0, 0, 0);
            c++;
        end
        chk("wait_owner_bound", 32'(owner == id && cnt >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_winc"},      32'(bus.winc),      32'd0);
        chk({tag, "_wdata"},     32'(bus.wdata),     32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_grant_id"},  32'(bus.grant_id),  32'd0);
    endtask

    // Monitor: compare each cycle's outputs against the oldest prediction.
    always @(negedge w_clk) begin
        if (w_rst && stat_q.size() > 0) begin
            mon_s = stat_q.pop_front();
            chk("busy",      32'(bus.busy),      32'(mon_s.busy));
            if (mon_s.busy) chk("grant_id", 32'(bus.grant_id), 32'(mon_s.gid));
            chk("req_ready", 32'(bus.req_ready), 32'(mon_s.ready));
            chk("winc",      32'(bus.winc),      32'(mon_s.winc));
            if (bus.winc) begin
                if (wr_q.size() > 0) begin
                    mon_w = wr_q.pop_front();
                    chk("wdata",     32'(bus.wdata),    32'(mon_w.d));
                    chk("write_src", 32'(bus.grant_id), 32'(mon_w.id));
                end else begin
                    n_checks++;
                    $display("FAIL write: unexpected winc with wdata %0h, expected no write", bus.wdata);
                end
            end else begin
                chk("wdata_idle", 32'(bus.wdata), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        pv = '0;
        pl = '0;
        for (int i = 0; i < N; i++) pd[i] = '0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.wfull     = 1'b0;

        // reset held with all requests valid
        #3;
        check_reset_outputs("rst");
        #20;
        check_reset_outputs("rst_hold");

        // all four single-word packets, producer 0 twice: grants 0,1,2,3,0
        gen_q[0].push_back({1'b1, 8'hA0});
        gen_q[0].push_back({1'b1, 8'hA1});
        gen_q[1].push_back({1'b1, 8'hB0});
        gen_q[2].push_back({1'b1, 8'hC0});
        gen_q[3].push_back({1'b1, 8'hD0});
        drain(60);

        // only producer 0, three-word packet
        gen_q[0].push_back({1'b0, 8'h11});
        gen_q[0].push_back({1'b0, 8'h22});
        gen_q[0].push_back({1'b1, 8'h33});
        drain(30);

        // producer 1 streams past MAX_BURST; producer 2 arrives mid-burst
        for (int i = 0; i < 12; i++) gen_q[1].push_back({1'b0, DW'(8'h40 + i)});
        gen_q[1].push_back({1'b1, 8'h4F});
        wait_owner(1, 3);
        gen_q[2].push_back({1'b1, 8'h5A});
        drain(60);

        // backpressure mid-burst for three cycles
        for (int i = 0; i < 5; i++) gen_q[3].push_back({1'b0, DW'(8'h60 + i)});
        gen_q[3].push_back({1'b1, 8'h6F});
        wait_owner(3, 2);
        repeat (3) step('0, 100, 0);
        drain(40);

        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) gen_q[2].push_back({1'b0, DW'(8'h70 + i)});
        gen_q[2].push_back({1'b1, 8'h7F});
        wait_owner(2, 2);
        #2;
        w_rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        stat_q.delete();
        wr_q.delete();
        owner = -1;
        ptr   = N - 1;
        cnt   = 0;
        gen_q[0].push_back({1'b1, 8'h80});
        repeat (2) @(posedge w_clk);
        drain(60);

        // randomized traffic with random backpressure
        repeat (400) step('1, 20, 30);
        drain(300);

        @(negedge w_clk);
        #1;
        chk("wr_q_leftover",   32'(wr_q.size()),   32'd0);
        chk("stat_q_leftover", 32'(stat_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
